// File: rtl/i2c_dac_target_pkg.sv
// Shared definitions for the MCP47FEB-style I2C DAC target: addresses,
// register/command codes, FSM encodings and the command-byte decoder.
package i2c_dac_target_pkg;

    localparam logic [6:0] DEFAULT_ADDRESS = 7'b110_0000;

    localparam logic [4:0] DAC0_REG = 5'd0;
    localparam logic [4:0] DAC1_REG = 5'd1;

    localparam logic [1:0] CMD_WRITE = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b11;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        CMD,
        WR_HI,
        WR_LO,
        RD_HI,
        RD_LO,
        MACK,
        IGNORE
    } state_t;

    // Position inside a byte: data bits, 8th bit seen, or inside the ack slot.
    typedef enum logic [1:0] {
        PH_BITS,
        PH_PEND,
        PH_ACK
    } phase_t;

    // Command byte is {reg[4:0], c[1:0], x}; the caller passes bits [7:1].
    function automatic logic cmd_valid(input logic [6:0] cmd_hi);
        logic [4:0] reg_code;
        logic [1:0] c_code;
        reg_code = cmd_hi[6:2];
        c_code   = cmd_hi[1:0];
        return ((reg_code == DAC0_REG) || (reg_code == DAC1_REG)) &&
               ((c_code == CMD_WRITE) || (c_code == CMD_READ));
    endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Joint SCL/SDA conditioning: 2-FF synchronizer, stability filter and
// registered START/STOP/SCL-edge strobes, so both lines share one latency.
module i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic start,
    output logic stop,
    output logic scl_rise,
    output logic scl_fall
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    filt;      // bit 0 = SCL, bit 1 = SDA
    logic [CW-1:0] cnt [2];
    logic          scl_q;
    logic          sda_q;

    // NOTE: the counter array is small state, not a RAM, so it is reset along
    // with the rest; everything resets to the idle-bus level (high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
            filt  <= 2'b11;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            sync1 <= {sda_i, scl_i};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(FILTER_LEN - 1)) begin
                    filt[i] <= sync2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
            start    <= 1'b0;
            stop     <= 1'b0;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
        end else begin
            scl_q    <= filt[0];
            sda_q    <= filt[1];
            start    <= scl_q & filt[0] & sda_q & ~filt[1];
            stop     <= scl_q & filt[0] & ~sda_q & filt[1];
            scl_rise <= ~scl_q & filt[0];
            scl_fall <= scl_q & ~filt[0];
        end
    end

    // Delayed SDA lines up with the strobes: valid for sampling on scl_rise.
    assign sda = sda_q;

endmodule

// File: rtl/i2c_dac_target.sv
// I2C target emulating the MCP47FEB volatile DAC0/DAC1 registers: write
// framing with continuous mode, read-back via repeated START.
module i2c_dac_target
    import i2c_dac_target_pkg::*;
#(
    parameter logic [6:0]  ADDRESS     = DEFAULT_ADDRESS,
    parameter int          FILTER_LEN  = 3,
    parameter logic [11:0] RESET_VALUE = 12'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_o,
    output logic [11:0] dac0_value,
    output logic [11:0] dac1_value,
    output logic        update,
    output logic        update_ch,
    output logic        busy,
    output logic        cmd_error
);

    logic sda;
    logic start;
    logic stop;
    logic scl_rise;
    logic scl_fall;

    i2c_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_line_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda      (sda),
        .start    (start),
        .stop     (stop),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall)
    );

    state_t      state,   state_d;
    phase_t      phase,   phase_d;
    logic [2:0]  bit_cnt, bit_cnt_d;
    logic [6:0]  shift,   shift_d;    // first seven bits of the current byte
    logic [3:0]  hi_nib,  hi_d;
    logic        ptr,     ptr_d;      // 0 = DAC0, 1 = DAC1
    logic [11:0] snap,    snap_d;
    logic        from_hi, from_hi_d;
    logic        sda_d;
    logic        busy_d;
    logic        commit;
    logic        cmd_err_d;

    logic [7:0]  rx_byte;
    logic [7:0]  tx_byte;

    assign rx_byte = {shift, sda};
    assign tx_byte = (state == RD_HI) ? {4'b0000, snap[11:8]} : snap[7:0];

    // NOTE: every variable below gets a default before any branch, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state;
        phase_d   = phase;
        bit_cnt_d = bit_cnt;
        shift_d   = shift;
        hi_d      = hi_nib;
        ptr_d     = ptr;
        snap_d    = snap;
        from_hi_d = from_hi;
        sda_d     = sda_o;
        busy_d    = busy;
        commit    = 1'b0;
        cmd_err_d = 1'b0;

        if (stop) begin
            state_d   = IDLE;
            phase_d   = PH_BITS;
            bit_cnt_d = '0;
            sda_d     = 1'b1;
            busy_d    = 1'b0;
        end else if (start) begin
            state_d   = ADDR;
            phase_d   = PH_BITS;
            bit_cnt_d = '0;
            sda_d     = 1'b1;
        end else begin
            case (state)
                ADDR, CMD, WR_HI, WR_LO: begin
                    if (phase == PH_BITS && scl_rise) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            phase_d = PH_PEND;
                            case (state)
                                ADDR: begin
                                    if (rx_byte[7:1] == ADDRESS) begin
                                        busy_d = 1'b1;
                                    end else begin
                                        state_d = IGNORE;
                                        phase_d = PH_BITS;
                                        busy_d  = 1'b0;
                                    end
                                end
                                CMD: begin
                                    if (cmd_valid(rx_byte[7:1])) begin
                                        ptr_d = rx_byte[3];
                                    end else begin
                                        state_d   = IGNORE;
                                        phase_d   = PH_BITS;
                                        cmd_err_d = 1'b1;
                                    end
                                end
                                WR_HI:   hi_d   = rx_byte[3:0];
                                default: commit = 1'b1;
                            endcase
                        end
                    end else if (phase == PH_PEND && scl_fall) begin
                        phase_d = PH_ACK;
                        sda_d   = 1'b0;
                    end else if (phase == PH_ACK && scl_fall) begin
                        phase_d = PH_BITS;
                        sda_d   = 1'b1;
                        case (state)
                            ADDR: begin
                                if (shift[0]) begin
                                    state_d = RD_HI;
                                    snap_d  = ptr ? dac1_value : dac0_value;
                                    sda_d   = 1'b0;   // MSB of {4'b0000, reg[11:8]}
                                end else begin
                                    state_d = CMD;
                                end
                            end
                            CMD:     state_d = (shift[2:1] == CMD_WRITE) ? WR_HI : IGNORE;
                            WR_HI:   state_d = WR_LO;
                            default: state_d = CMD;
                        endcase
                    end
                end
                RD_HI, RD_LO: begin
                    if (phase == PH_BITS && scl_rise) begin
                        bit_cnt_d = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) phase_d = PH_PEND;
                    end else if (phase == PH_BITS && scl_fall) begin
                        sda_d = tx_byte[~bit_cnt];
                    end else if (phase == PH_PEND && scl_fall) begin
                        state_d   = MACK;
                        phase_d   = PH_BITS;
                        sda_d     = 1'b1;
                        from_hi_d = (state == RD_HI);
                    end
                end
                MACK: begin
                    if (phase == PH_BITS && scl_rise) begin
                        if (sda) state_d = IGNORE;
                        else     phase_d = PH_PEND;
                    end else if (phase == PH_PEND && scl_fall) begin
                        phase_d = PH_BITS;
                        if (from_hi) begin
                            state_d = RD_LO;
                            sda_d   = snap[7];
                        end else begin
                            state_d = RD_HI;
                            snap_d  = ptr ? dac1_value : dac0_value;
                            sda_d   = 1'b0;
                        end
                    end
                end
                IDLE, IGNORE: sda_d = 1'b1;
                default: begin
                    state_d = IDLE;
                    sda_d   = 1'b1;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values computed above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            phase     <= PH_BITS;
            bit_cnt   <= '0;
            shift     <= '0;
            hi_nib    <= '0;
            ptr       <= 1'b0;
            snap      <= '0;
            from_hi   <= 1'b0;
            sda_o     <= 1'b1;
            busy      <= 1'b0;
            cmd_error <= 1'b0;
        end else begin
            state     <= state_d;
            phase     <= phase_d;
            bit_cnt   <= bit_cnt_d;
            shift     <= shift_d;
            hi_nib    <= hi_d;
            ptr       <= ptr_d;
            snap      <= snap_d;
            from_hi   <= from_hi_d;
            sda_o     <= sda_d;
            busy      <= busy_d;
            cmd_error <= cmd_err_d;
        end
    end

    // Commit happens only on the completed low byte, so aborts never tear a value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dac0_value <= RESET_VALUE;
            dac1_value <= RESET_VALUE;
            update     <= 1'b0;
            update_ch  <= 1'b0;
        end else begin
            update <= commit;
            if (commit) begin
                if (ptr) dac1_value <= {hi_nib, rx_byte};
                else     dac0_value <= {hi_nib, rx_byte};
                update_ch <= ptr;
            end
        end
    end

endmodule

// File: tb/tb_i2c_dac_target.sv
// Directed bench for i2c_dac_target: a bit-banged I2C master on a wired-AND
// SDA line, with immediate assertions at every comparison point.
module tb_i2c_dac_target;

    localparam int Q = 12;   // quarter SCL period in clk cycles

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        m_scl = 1'b1;
    logic        m_sda = 1'b1;
    logic        sda_o;
    logic [11:0] dac0_value;
    logic [11:0] dac1_value;
    logic        update;
    logic        update_ch;
    logic        busy;
    logic        cmd_error;
    wire         sda_bus = m_sda & sda_o;

    int tests = 0;
    int fails = 0;
    int upd_total  = 0;
    int err_total  = 0;
    int busy_total = 0;

    always #5 clk = ~clk;

    i2c_dac_target dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl_i      (m_scl),
        .sda_i      (sda_bus),
        .sda_o      (sda_o),
        .dac0_value (dac0_value),
        .dac1_value (dac1_value),
        .update     (update),
        .update_ch  (update_ch),
        .busy       (busy),
        .cmd_error  (cmd_error)
    );

    always @(negedge clk) begin
        if (update)    upd_total++;
        if (cmd_error) err_total++;
        if (busy)      busy_total++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bit_out(input logic b);
        m_sda = b;
        tick(Q);
        m_scl = 1'b1;
        tick(2 * Q);
        m_scl = 1'b0;
        tick(Q);
    endtask

    task automatic bit_in(output logic b);
        m_sda = 1'b1;
        tick(Q);
        m_scl = 1'b1;
        tick(Q);
        b = sda_bus;
        tick(Q);
        m_scl = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1;
        tick(Q);
        m_scl = 1'b1;
        tick(Q);
        m_sda = 1'b0;
        tick(Q);
        m_scl = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0;
        tick(Q);
        m_scl = 1'b1;
        tick(Q);
        m_sda = 1'b1;
        tick(2 * Q);
    endtask

    task automatic xfer(input logic [7:0] v, input logic exp_nack, input string tag);
        logic nack;
        for (int i = 7; i >= 0; i--) bit_out(v[i]);
        bit_in(nack);
        check(tag, 32'(nack), 32'(exp_nack));
    endtask

    task automatic recv(input logic master_nack, input logic [7:0] exp, input string tag);
        logic       b;
        logic [7:0] v;
        v = '0;
        for (int i = 7; i >= 0; i--) begin
            bit_in(b);
            v[i] = b;
        end
        bit_out(master_nack);
        check(tag, 32'(v), 32'(exp));
    endtask

    int upd0;
    int err0;
    int busy0;

    initial begin
        // Reset values
        tick(3);
        check("rst_sda_o", 32'(sda_o), 32'h1);
        check("rst_dac0", 32'(dac0_value), 32'h000);
        check("rst_dac1", 32'(dac1_value), 32'h000);
        check("rst_update", 32'(update), 32'h0);
        check("rst_update_ch", 32'(update_ch), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_cmd_error", 32'(cmd_error), 32'h0);
        rst_n = 1'b1;
        tick(5);

        // Single write to DAC1
        upd0 = upd_total;
        i2c_start();
        xfer(8'hC0, 1'b0, "w1_addr_ack");
        xfer(8'h08, 1'b0, "w1_cmd_ack");
        xfer(8'h0A, 1'b0, "w1_hi_ack");
        xfer(8'hBC, 1'b0, "w1_lo_ack");
        check("w1_busy_before_stop", 32'(busy), 32'h1);
        i2c_stop();
        check("w1_dac1", 32'(dac1_value), 32'hABC);
        check("w1_dac0", 32'(dac0_value), 32'h000);
        check("w1_update_pulses", 32'(upd_total - upd0), 32'd1);
        check("w1_update_ch", 32'(update_ch), 32'h1);
        check("w1_busy_after_stop", 32'(busy), 32'h0);

        // Continuous write to both channels
        upd0 = upd_total;
        i2c_start();
        xfer(8'hC0, 1'b0, "w2_addr_ack");
        xfer(8'h00, 1'b0, "w2_cmd0_ack");
        xfer(8'h01, 1'b0, "w2_hi0_ack");
        xfer(8'h23, 1'b0, "w2_lo0_ack");
        xfer(8'h08, 1'b0, "w2_cmd1_ack");
        xfer(8'h04, 1'b0, "w2_hi1_ack");
        xfer(8'h56, 1'b0, "w2_lo1_ack");
        i2c_stop();
        check("w2_dac0", 32'(dac0_value), 32'h123);
        check("w2_dac1", 32'(dac1_value), 32'h456);
        check("w2_update_pulses", 32'(upd_total - upd0), 32'd2);
        check("w2_update_ch", 32'(update_ch), 32'h1);

        // Write DAC1 then read it back through repeated START, with wrap
        upd0 = upd_total;
        i2c_start();
        xfer(8'hC0, 1'b0, "rd_wr_addr_ack");
        xfer(8'h08, 1'b0, "rd_wr_cmd_ack");
        xfer(8'h06, 1'b0, "rd_wr_hi_ack");
        xfer(8'h78, 1'b0, "rd_wr_lo_ack");
        i2c_stop();
        check("rd_wr_dac1", 32'(dac1_value), 32'h678);
        check("rd_wr_update_pulses", 32'(upd_total - upd0), 32'd1);
        i2c_start();
        xfer(8'hC0, 1'b0, "rd_addr_w_ack");
        xfer(8'h0E, 1'b0, "rd_cmd_ack");
        i2c_start();
        xfer(8'hC1, 1'b0, "rd_addr_r_ack");
        recv(1'b0, 8'h06, "rd_hi_byte");
        recv(1'b0, 8'h78, "rd_lo_byte");
        recv(1'b0, 8'h06, "rd_wrap_hi_byte");
        recv(1'b1, 8'h78, "rd_wrap_lo_byte");
        tick(2);
        check("rd_sda_released", 32'(sda_o), 32'h1);
        check("rd_busy_until_stop", 32'(busy), 32'h1);
        i2c_stop();
        check("rd_busy_after_stop", 32'(busy), 32'h0);
        check("rd_dac1_unchanged", 32'(dac1_value), 32'h678);

        // Foreign address 0xC2
        err0  = err_total;
        busy0 = busy_total;
        i2c_start();
        xfer(8'hC2, 1'b1, "na_addr_nack");
        xfer(8'h08, 1'b1, "na_next_byte_nack");
        i2c_stop();
        check("na_dac0", 32'(dac0_value), 32'h123);
        check("na_dac1", 32'(dac1_value), 32'h678);
        check("na_cmd_error", 32'(err_total - err0), 32'd0);
        check("na_busy_cycles", 32'(busy_total - busy0), 32'd0);

        // Bad command (register 2)
        err0 = err_total;
        upd0 = upd_total;
        i2c_start();
        xfer(8'hC0, 1'b0, "bc_addr_ack");
        xfer(8'h10, 1'b1, "bc_cmd_nack");
        xfer(8'h0A, 1'b1, "bc_hi_ignored");
        xfer(8'hBC, 1'b1, "bc_lo_ignored");
        i2c_stop();
        check("bc_cmd_error_pulses", 32'(err_total - err0), 32'd1);
        check("bc_no_update", 32'(upd_total - upd0), 32'd0);
        check("bc_dac0", 32'(dac0_value), 32'h123);
        check("bc_dac1", 32'(dac1_value), 32'h678);
        check("bc_busy_after_stop", 32'(busy), 32'h0);

        // Abort: STOP after the high byte discards it
        upd0 = upd_total;
        i2c_start();
        xfer(8'hC0, 1'b0, "ab_addr_ack");
        xfer(8'h00, 1'b0, "ab_cmd_ack");
        xfer(8'h0F, 1'b0, "ab_hi_ack");
        i2c_stop();
        check("ab_no_update", 32'(upd_total - upd0), 32'd0);
        check("ab_dac0_kept", 32'(dac0_value), 32'h123);

        // Reset asserted mid-address
        i2c_start();
        bit_out(1'b1);
        bit_out(1'b1);
        bit_out(1'b0);
        bit_out(1'b0);
        rst_n = 1'b0;
        #1;
        check("mr_sda_o", 32'(sda_o), 32'h1);
        check("mr_dac0", 32'(dac0_value), 32'h000);
        check("mr_dac1", 32'(dac1_value), 32'h000);
        check("mr_update", 32'(update), 32'h0);
        check("mr_update_ch", 32'(update_ch), 32'h0);
        check("mr_busy", 32'(busy), 32'h0);
        check("mr_cmd_error", 32'(cmd_error), 32'h0);
        m_scl = 1'b1;
        m_sda = 1'b1;
        tick(4);
        rst_n = 1'b1;
        tick(10);

        // Post-reset write to DAC0; upper nibble of the high byte is ignored
        upd0 = upd_total;
        i2c_start();
        xfer(8'hC0, 1'b0, "pr_addr_ack");
        xfer(8'h00, 1'b0, "pr_cmd_ack");
        xfer(8'hF5, 1'b0, "pr_hi_ack");
        xfer(8'hA5, 1'b0, "pr_lo_ack");
        i2c_stop();
        check("pr_dac0", 32'(dac0_value), 32'h5A5);
        check("pr_dac1", 32'(dac1_value), 32'h000);
        check("pr_update_pulses", 32'(upd_total - upd0), 32'd1);
        check("pr_update_ch", 32'(update_ch), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
